// File: rtl/crc_stream_engine.sv
// Streaming CRC engine: BYTES bytes per beat, programmable polynomial/init/xorout/reflection.
// Defining CRC_CHECK_EN adds the crc_ok residue-check output.
module crc_stream_engine #(
   parameter int unsigned BYTES   = 4,
   parameter int unsigned CRC_W   = 32,
   parameter logic [31:0] POLY    = 32'h04C11DB7,
   parameter logic [31:0] INIT    = 32'hFFFFFFFF,
   parameter logic [31:0] XOROUT  = 32'hFFFFFFFF,
   parameter bit          REFLECT = 1'b1,
   parameter logic [31:0] RESIDUE = 32'hDEBB20E3
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               flush,
   input  logic               s_valid,
   output logic               s_ready,
   input  logic [8*BYTES-1:0] s_data,
   input  logic [BYTES-1:0]   s_keep,
   input  logic               s_last,
   output logic               m_valid,
   input  logic               m_ready,
   output logic [CRC_W-1:0]   m_crc,
   output logic [15:0]        m_len
`ifdef CRC_CHECK_EN
   ,
   output logic               crc_ok
`endif
);

   function automatic logic [CRC_W-1:0] bit_rev(input logic [CRC_W-1:0] v);
      logic [CRC_W-1:0] r;
      r = '0;
      for (int i = 0; i < CRC_W; i++) begin
         r[i] = v[CRC_W-1-i];
      end
      return r;
   endfunction

   localparam logic [CRC_W-1:0] PolyN = POLY[CRC_W-1:0];
   localparam logic [CRC_W-1:0] PolyR = bit_rev(PolyN);
   localparam logic [CRC_W-1:0] InitV = INIT[CRC_W-1:0];
   localparam logic [CRC_W-1:0] XorV  = XOROUT[CRC_W-1:0];

   // One byte through eight shift/XOR steps; direction fixed by REFLECT.
   function automatic logic [CRC_W-1:0] fold_byte(input logic [CRC_W-1:0] c_in,
                                                  input logic [7:0]       d);
      logic [CRC_W-1:0] c;
      logic             fb;
      c = c_in;
      for (int i = 0; i < 8; i++) begin
         if (REFLECT) begin
            fb = c[0] ^ d[i];
            c  = (c >> 1) ^ (fb ? PolyR : '0);
         end else begin
            fb = c[CRC_W-1] ^ d[7-i];
            c  = (c << 1) ^ (fb ? PolyN : '0);
         end
      end
      return c;
   endfunction

   typedef enum logic {StAccum, StHold} state_e;

   state_e           state_q, state_d;
   logic [CRC_W-1:0] crc_q, crc_d;
   logic [15:0]      len_q, len_d;
   logic [CRC_W-1:0] res_crc_q, res_crc_d;
   logic [15:0]      res_len_q, res_len_d;

   logic [CRC_W-1:0] crc_beat;
   logic [4:0]       cnt;
   logic             en;
   logic [16:0]      len_sum;
   logic [15:0]      len_beat;
   logic             accept;
   logic             close;

   assign m_valid = (state_q == StHold);
   assign s_ready = !m_valid || m_ready;
   assign accept  = s_valid && s_ready;
   assign close   = accept && s_last && !flush;
   assign m_crc   = res_crc_q;
   assign m_len   = res_len_q;

   // Last beat folds only the leading run of kept bytes; earlier beats fold everything.
   always_comb begin
      crc_beat = crc_q;
      cnt      = '0;
      en       = 1'b1;
      for (int b = 0; b < BYTES; b++) begin
         en = en & (!s_last | s_keep[b]);
         if (en) begin
            crc_beat = fold_byte(crc_beat, s_data[8*b +: 8]);
            cnt      = cnt + 5'd1;
         end
      end
   end

   assign len_sum  = {1'b0, len_q} + {12'd0, cnt};
   assign len_beat = len_sum[16] ? 16'hFFFF : len_sum[15:0];

   always_comb begin
      state_d   = state_q;
      crc_d     = crc_q;
      len_d     = len_q;
      res_crc_d = res_crc_q;
      res_len_d = res_len_q;
      unique case (state_q)
         StAccum: if (close) state_d = StHold;
         StHold:  if (!close && m_ready) state_d = StAccum;
         default: state_d = StAccum;
      endcase
      if (flush || close) begin
         crc_d = InitV;
         len_d = '0;
      end else if (accept) begin
         crc_d = crc_beat;
         len_d = len_beat;
      end
      if (close) begin
         res_crc_d = crc_beat ^ XorV;
         res_len_d = len_beat;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StAccum;
         crc_q     <= InitV;
         len_q     <= '0;
         res_crc_q <= '0;
         res_len_q <= '0;
      end else begin
         state_q   <= state_d;
         crc_q     <= crc_d;
         len_q     <= len_d;
         res_crc_q <= res_crc_d;
         res_len_q <= res_len_d;
      end
   end

`ifdef CRC_CHECK_EN
   logic ok_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ok_q <= 1'b0;
      end else if (close) begin
         ok_q <= (crc_beat == RESIDUE[CRC_W-1:0]);
      end
   end

   assign crc_ok = ok_q;
`endif

endmodule

// File: tb/tb_crc_stream_engine.sv
// Bench for crc_stream_engine: queue-based byte model checked every cycle, directed literals,
// randomized framing/backpressure/flush, plus REFLECT=0 instances at BYTES=8 and BYTES=1.
module tb_crc_stream_engine;
   localparam int unsigned BYTES = 4;
   localparam logic [31:0] XOR_OUT = 32'hFFFFFFFF;
   localparam logic [31:0] RESIDUE = 32'hDEBB20E3;

   typedef logic [7:0] bq_t[$];

   logic        clk;
   logic        rst_n, flush, s_valid, s_ready, s_last, m_valid, m_ready;
   logic [31:0] s_data;
   logic [3:0]  s_keep;
   logic [31:0] m_crc;
   logic [15:0] m_len;
   logic        w_valid, w_ready, w_last, w_mvalid, w_flush, w_mready;
   logic [63:0] w_data;
   logic [7:0]  w_keep;
   logic [31:0] w_crc;
   logic [15:0] w_len;
   logic        n_valid, n_ready, n_last, n_mvalid;
   logic [7:0]  n_data;
   logic [0:0]  n_keep;
   logic [31:0] n_crc;
   logic [15:0] n_len;
`ifdef CRC_CHECK_EN
   logic        crc_ok, w_ok, n_ok;
`endif

   int          total = 0;
   int          bad = 0;
   int          cyc = 0;
   bit          rnd_ready = 0;
   logic        exp_valid = 0;
   logic [31:0] exp_crc = '0;
   logic [15:0] exp_len = '0;
   logic        exp_ok = 0;

   crc_stream_engine dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .s_valid(s_valid), .s_ready(s_ready),
      .s_data(s_data), .s_keep(s_keep), .s_last(s_last), .m_valid(m_valid),
      .m_ready(m_ready), .m_crc(m_crc), .m_len(m_len)
`ifdef CRC_CHECK_EN
      , .crc_ok(crc_ok)
`endif
   );

   crc_stream_engine #(.BYTES(8), .REFLECT(1'b0)) dut_w (
      .clk(clk), .rst_n(rst_n), .flush(w_flush), .s_valid(w_valid), .s_ready(w_ready),
      .s_data(w_data), .s_keep(w_keep), .s_last(w_last), .m_valid(w_mvalid),
      .m_ready(w_mready), .m_crc(w_crc), .m_len(w_len)
`ifdef CRC_CHECK_EN
      , .crc_ok(w_ok)
`endif
   );

   crc_stream_engine #(.BYTES(1), .REFLECT(1'b0)) dut_n (
      .clk(clk), .rst_n(rst_n), .flush(w_flush), .s_valid(n_valid), .s_ready(n_ready),
      .s_data(n_data), .s_keep(n_keep), .s_last(n_last), .m_valid(n_mvalid),
      .m_ready(w_mready), .m_crc(n_crc), .m_len(n_len)
`ifdef CRC_CHECK_EN
      , .crc_ok(n_ok)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, got, want);
      end
   endtask

   // Classic byte-at-a-time CRC-32 (reflected) and CRC-32/BZIP2 (normal); returns pre-xorout register.
   function automatic logic [31:0] model_reg(input bq_t msg, input bit refl);
      logic [31:0] r;
      r = 32'hFFFFFFFF;
      foreach (msg[k]) begin
         if (refl) begin
            r = r ^ {24'd0, msg[k]};
            for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
         end else begin
            r = r ^ {msg[k], 24'd0};
            for (int i = 0; i < 8; i++) r = r[31] ? ((r << 1) ^ 32'h04C11DB7) : (r << 1);
         end
      end
      return r;
   endfunction

   function automatic bq_t str_bytes(input string s);
      bq_t q;
      for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
      return q;
   endfunction

   // Reference model, compared every cycle.
   initial begin : cmp
      logic        exp_sready;
      int          n;
      logic [31:0] pre;
      bq_t         cur;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            chk("rst m_valid", m_valid, 0);
            chk("rst m_crc", m_crc, 0);
            chk("rst m_len", m_len, 0);
`ifdef CRC_CHECK_EN
            chk("rst crc_ok", crc_ok, 0);
`endif
            cur.delete();
            exp_valid = 0;
         end else begin
            exp_sready = !exp_valid || m_ready;
            chk("s_ready", s_ready, exp_sready);
            chk("m_valid", m_valid, exp_valid);
            if (exp_valid) begin
               chk("m_crc", m_crc, exp_crc);
               chk("m_len", m_len, exp_len);
`ifdef CRC_CHECK_EN
               chk("crc_ok", crc_ok, exp_ok);
`endif
            end
            if (exp_valid && m_ready) exp_valid = 0;
            if (s_valid && exp_sready && !flush) begin
               n = 0;
               if (s_last) begin
                  while (n < BYTES && s_keep[n]) n++;
               end else begin
                  n = BYTES;
               end
               for (int k = 0; k < n; k++) cur.push_back(s_data[8*k +: 8]);
               if (s_last) begin
                  pre       = model_reg(cur, 1'b1);
                  exp_crc   = pre ^ XOR_OUT;
                  exp_len   = (cur.size() > 65535) ? 16'hFFFF : 16'(cur.size());
                  exp_ok    = (pre == RESIDUE);
                  exp_valid = 1;
                  cur.delete();
               end
            end else if (flush) begin
               cur.delete();
            end
         end
      end
   end

   initial forever begin
      @(posedge clk);
      #1;
      if (rnd_ready) m_ready = ($urandom_range(0, 3) != 0);
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drive(input logic [31:0] d, input logic [3:0] k, input logic l,
                        input logic f);
      logic rdy;
      s_valid = 1; s_data = d; s_keep = k; s_last = l; flush = f;
      for (int t = 0; t < 400; t++) begin
         @(negedge clk);
         rdy = s_ready;
         @(posedge clk);
         #1;
         if (rdy) begin
            s_valid = 0; s_last = 0; flush = 0;
            return;
         end
      end
      chk("accept timeout", 0, 1);
      s_valid = 0; s_last = 0; flush = 0;
   endtask

   task automatic send_123(input logic f_last);
      drive(32'h34333231, 4'hF, 0, 0);
      drive(32'h38373635, 4'hF, 0, 0);
      drive(32'h00000039, 4'h1, 1, f_last);
   endtask

   task automatic expect_result(input string name, input logic [31:0] c, input logic [15:0] l,
                                input logic ok);
      int t;
      for (t = 0; t < 20; t++) begin
         @(negedge clk);
         if (m_valid) break;
      end
      chk({name, " latency"}, t, 0);
      chk({name, " m_valid"}, m_valid, 1);
      chk({name, " m_crc"}, m_crc, c);
      chk({name, " m_len"}, m_len, l);
`ifdef CRC_CHECK_EN
      chk({name, " crc_ok"}, crc_ok, ok);
`else
      if (ok === 1'bx) chk({name, " ok arg"}, ok, 0);
`endif
      @(posedge clk);
      #1;
   endtask

   task automatic drive_w(input logic [63:0] d, input logic [7:0] k, input logic l);
      logic rdy;
      w_valid = 1; w_data = d; w_keep = k; w_last = l;
      for (int t = 0; t < 50; t++) begin
         @(negedge clk);
         rdy = w_ready;
         @(posedge clk);
         #1;
         if (rdy) begin
            w_valid = 0; w_last = 0;
            return;
         end
      end
      chk("w accept timeout", 0, 1);
      w_valid = 0; w_last = 0;
   endtask

   task automatic drive_n(input logic [7:0] d, input logic l);
      logic rdy;
      n_valid = 1; n_data = d; n_keep = 1'b1; n_last = l;
      for (int t = 0; t < 50; t++) begin
         @(negedge clk);
         rdy = n_ready;
         @(posedge clk);
         #1;
         if (rdy) begin
            n_valid = 0; n_last = 0;
            return;
         end
      end
      chk("n accept timeout", 0, 1);
      n_valid = 0; n_last = 0;
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin : main
      bq_t         q;
      logic [31:0] crc_a;
      int          t0, nb, t;
      rst_n = 0; flush = 0; s_valid = 0; s_last = 0; s_data = '0; s_keep = '0; m_ready = 1;
      w_valid = 0; w_last = 0; w_data = '0; w_keep = '0; w_flush = 0; w_mready = 1;
      n_valid = 0; n_last = 0; n_data = '0; n_keep = '0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1;
      @(negedge clk);
      chk("s_ready after reset", s_ready, 1);
      @(posedge clk);
      #1;

      // Pin the model itself.
      chk("model crc32", model_reg(str_bytes("123456789"), 1'b1) ^ XOR_OUT, 32'hCBF43926);
      chk("model bzip2", model_reg(str_bytes("123456789"), 1'b0) ^ XOR_OUT, 32'hFC891918);

      send_123(0);
      expect_result("t1", 32'hCBF43926, 16'd9, 0);
      drive(32'h0, 4'h1, 1, 0);
      expect_result("t2 one zero", 32'hD202EF8D, 16'd1, 0);
      drive(32'h0, 4'h0, 1, 0);
      expect_result("t2 empty", 32'h0, 16'd0, 0);

      // Backpressure with a second frame pending, then back-to-back frames.
      q = '{8'h44, 8'h33, 8'h22, 8'h11};
      crc_a = model_reg(q, 1'b1) ^ XOR_OUT;
      m_ready = 0;
      drive(32'h11223344, 4'hF, 1, 0);
      s_valid = 1; s_data = 32'h55667788; s_keep = 4'hF; s_last = 1;
      repeat (5) begin
         @(negedge clk);
         chk("hold s_ready", s_ready, 0);
         chk("hold m_crc", m_crc, crc_a);
         @(posedge clk);
         #1;
      end
      m_ready = 1;
      @(negedge clk);
      chk("release s_ready", s_ready, 1);
      @(posedge clk);
      #1;
      s_valid = 0; s_last = 0;
      t0 = cyc;
      repeat (4) drive($urandom, 4'hF, 1, 0);
      chk("b2b cycles", cyc - t0, 4);
      idle(3);

      // Flush mid-frame, flush with pending result, resets, flush on last beat.
      drive(32'h34333231, 4'hF, 0, 0);
      drive(32'h38373635, 4'hF, 0, 1);
      send_123(0);
      expect_result("t4 flush mid", 32'hCBF43926, 16'd9, 0);
      m_ready = 0;
      drive(32'h0, 4'h1, 1, 0);
      flush = 1;
      idle(1);
      flush = 0;
      @(negedge clk);
      chk("flush keeps m_valid", m_valid, 1);
      chk("flush keeps m_crc", m_crc, 32'hD202EF8D);
      @(posedge clk);
      #1;
      m_ready = 1;
      idle(2);
      drive(32'h34333231, 4'hF, 0, 0);
      rst_n = 0;
      idle(2);
      rst_n = 1;
      idle(1);
      send_123(0);
      expect_result("t4 reset mid", 32'hCBF43926, 16'd9, 0);
      m_ready = 0;
      drive(32'h0, 4'h1, 1, 0);
      rst_n = 0;
      @(negedge clk);
      chk("reset hold m_valid", m_valid, 0);
      chk("reset hold m_len", m_len, 0);
      @(posedge clk);
      #1;
      rst_n = 1; m_ready = 1;
      idle(1);
      send_123(1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("flush last no m_valid", m_valid, 0);
      end
      @(posedge clk);
      #1;
      send_123(0);
      expect_result("t4 after flush", 32'hCBF43926, 16'd9, 0);

`ifdef CRC_CHECK_EN
      drive(32'h34333231, 4'hF, 0, 0);
      drive(32'h38373635, 4'hF, 0, 0);
      drive(32'hF4392639, 4'hF, 0, 0);
      drive(32'h000000CB, 4'h1, 1, 0);
      expect_result("t5 residue", 32'h2144DF1C, 16'd13, 1);
      drive(32'h34333230, 4'hF, 0, 0);
      drive(32'h38373635, 4'hF, 0, 0);
      drive(32'hF4392639, 4'hF, 0, 0);
      drive(32'h000000CB, 4'h1, 1, 0);
      @(negedge clk);
      chk("t5 flipped crc_ok", crc_ok, 0);
      @(posedge clk);
      #1;
`endif

      // REFLECT=0 at BYTES=8 and BYTES=1.
      drive_w(64'h3837363534333231, 8'hFF, 0);
      drive_w(64'h39, 8'h01, 1);
      for (t = 0; t < 20 && !w_mvalid; t++) @(negedge clk);
      chk("t6 w8 m_valid", w_mvalid, 1);
      chk("t6 w8 m_crc", w_crc, 32'hFC891918);
      chk("t6 w8 m_len", w_len, 9);
      @(posedge clk);
      #1;
      q = str_bytes("123456789");
      for (int i = 0; i < 9; i++) drive_n(q[i], i == 8);
      for (t = 0; t < 20 && !n_mvalid; t++) @(negedge clk);
      chk("t6 w1 m_valid", n_mvalid, 1);
      chk("t6 w1 m_crc", n_crc, 32'hFC891918);
      chk("t6 w1 m_len", n_len, 9);
      @(posedge clk);
      #1;

      // Random framing, keep, gaps, flushes and backpressure.
      rnd_ready = 1;
      for (int f = 0; f < 150; f++) begin
         nb = $urandom_range(1, 6);
         for (int b = 0; b < nb; b++) begin
            if ($urandom_range(0, 3) == 0) idle(1);
            drive($urandom, 4'($urandom), b == nb - 1, $urandom_range(0, 29) == 0);
         end
      end
      rnd_ready = 0;
      m_ready = 1;
      idle(3);

      // Length saturation: 65600 bytes.
      for (int i = 0; i < 16399; i++) drive($urandom, 4'hF, 0, 0);
      drive($urandom, 4'hF, 1, 0);
      @(negedge clk);
      chk("sat m_len", m_len, 16'hFFFF);
      @(posedge clk);
      #1;
      idle(5);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
